// File: rtl/credito_bebida.sv
// Credit accumulator and dispense/change sequencer for the beverage machine.
// Defining CANCEL_EN adds the cancel input, which returns the full credit as change.
module credito_bebida #(
  parameter int CREDIT_W    = 12,
  parameter int MAX_CREDIT  = 2000,
  parameter int PRICE_A     = 500,
  parameter int PRICE_B     = 700,
  parameter int PRICE_C     = 1000,
  parameter int DISP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                suma100,
  input  logic                suma500,
  input  logic [2:0]          sel,
`ifdef CANCEL_EN
  input  logic                cancel,
`endif
  output logic [CREDIT_W-1:0] credito,
  output logic                dispensar,
  output logic [2:0]          bebida,
  output logic                cambio100,
  output logic                cambio500,
  output logic                rechazo,
  output logic                falta,
  output logic                ocupado
);
  localparam int CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam int SUM_W = CREDIT_W + 1;

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [2:0]          bebida_reg, bebida_next;
  logic                disp_reg, disp_next;
  logic                c100_reg, c100_next;
  logic                c500_reg, c500_next;
  logic                rech_reg, rech_next;
  logic                falta_reg, falta_next;
  logic                ocup_reg, ocup_next;

  logic                cancel_req, coin, valid_sel, give_change;
  logic [SUM_W-1:0]    coin_val, sum;
  logic [CREDIT_W-1:0] price;

`ifdef CANCEL_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
`endif

  assign coin     = suma100 | suma500;
  assign coin_val = (suma100 ? SUM_W'(100) : '0) + (suma500 ? SUM_W'(500) : '0);
  assign sum      = {1'b0, credit_reg} + coin_val;

  always_comb begin
    valid_sel = 1'b1;
    price     = '0;
    case (sel)
      3'b001:  price = CREDIT_W'(PRICE_A);
      3'b010:  price = CREDIT_W'(PRICE_B);
      3'b100:  price = CREDIT_W'(PRICE_C);
      default: valid_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    cnt_next    = cnt_reg;
    bebida_next = bebida_reg;
    c100_next   = 1'b0;
    c500_next   = 1'b0;
    rech_next   = 1'b0;
    falta_next  = 1'b0;
    give_change = 1'b0;

    case (state_reg)
      IDLE, CREDIT: begin
        // Priority: cancel, then a valid selection, then coins.
        if (cancel_req) begin
          rech_next  = coin;
          state_next = CHANGE;
        end else if (valid_sel) begin
          rech_next = coin;
          if (credit_reg >= price) begin
            credit_next = credit_reg - price;
            bebida_next = sel;
            cnt_next    = CNT_W'(DISP_CYCLES - 1);
            state_next  = DISPENSE;
          end else begin
            falta_next = 1'b1;
          end
        end else if (coin) begin
          if (sum > SUM_W'(MAX_CREDIT)) begin
            rech_next = 1'b1;
          end else begin
            credit_next = sum[CREDIT_W-1:0];
            state_next  = CREDIT;
          end
        end
      end
      DISPENSE: begin
        rech_next = coin;
        if (cnt_reg == '0) begin
          // The first change coin is issued on the same edge that ends the dispense.
          if (credit_reg != '0) begin
            state_next  = CHANGE;
            give_change = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      CHANGE: begin
        rech_next = coin;
        if (credit_reg == '0) state_next = IDLE;
        else                  give_change = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (give_change) begin
      if (credit_reg >= CREDIT_W'(500)) begin
        c500_next   = 1'b1;
        credit_next = credit_reg - CREDIT_W'(500);
      end else begin
        c100_next   = 1'b1;
        credit_next = credit_reg - CREDIT_W'(100);
      end
    end

    if (state_next != DISPENSE) bebida_next = 3'b000;
    disp_next = (state_next == DISPENSE);
    ocup_next = (state_next == DISPENSE) || (state_next == CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      credit_reg <= '0;
      cnt_reg    <= '0;
      bebida_reg <= 3'b000;
      disp_reg   <= 1'b0;
      c100_reg   <= 1'b0;
      c500_reg   <= 1'b0;
      rech_reg   <= 1'b0;
      falta_reg  <= 1'b0;
      ocup_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      cnt_reg    <= cnt_next;
      bebida_reg <= bebida_next;
      disp_reg   <= disp_next;
      c100_reg   <= c100_next;
      c500_reg   <= c500_next;
      rech_reg   <= rech_next;
      falta_reg  <= falta_next;
      ocup_reg   <= ocup_next;
    end
  end

  assign credito   = credit_reg;
  assign dispensar = disp_reg;
  assign bebida    = bebida_reg;
  assign cambio100 = c100_reg;
  assign cambio500 = c500_reg;
  assign rechazo   = rech_reg;
  assign falta     = falta_reg;
  assign ocupado   = ocup_reg;
endmodule

// File: tb/tb_credito_bebida.sv
// Self-checking bench for credito_bebida: a timeline model of expected outputs
// checked every cycle, plus directed scenarios with literal expectations.
module tb_credito_bebida;
  localparam int MAXC = 2000;
  localparam int D    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        suma100 = 1'b0, suma500 = 1'b0, cancel = 1'b0;
  logic [2:0]  sel = 3'b000;
  logic [11:0] credito;
  logic        dispensar, cambio100, cambio500, rechazo, falta, ocupado;
  logic [2:0]  bebida;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  credito_bebida dut (
    .clk(clk), .rst(rst), .suma100(suma100), .suma500(suma500), .sel(sel),
`ifdef CANCEL_EN
    .cancel(cancel),
`endif
    .credito(credito), .dispensar(dispensar), .bebida(bebida),
    .cambio100(cambio100), .cambio500(cambio500), .rechazo(rechazo),
    .falta(falta), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: while idle, apply the purchase/coin rules; a purchase or cancel
  // schedules the whole busy period as a queue of per-cycle output records.
  typedef struct {
    logic       disp;
    logic [2:0] beb;
    logic       c100;
    logic       c500;
    int         cred;
  } ent_t;

  ent_t       tl[$];
  int         m_credit = 0;
  int         e_cred = 0;
  logic [2:0] e_beb = 3'b000;
  logic       e_disp = 0, e_c100 = 0, e_c500 = 0, e_rech = 0, e_falta = 0, e_ocup = 0;

  function automatic int price_of(input logic [2:0] s);
    case (s)
      3'b001:  return 500;
      3'b010:  return 700;
      3'b100:  return 1000;
      default: return -1;
    endcase
  endfunction

  task automatic push_ent(input logic disp, input logic [2:0] beb,
                          input logic c100, input logic c500, input int cred);
    ent_t e;
    e.disp = disp; e.beb = beb; e.c100 = c100; e.c500 = c500; e.cred = cred;
    tl.push_back(e);
  endtask

  task automatic push_change(input int amount);
    int rem = amount;
    int n500 = amount / 500;
    int n100 = (amount % 500) / 100;
    for (int i = 0; i < n500; i++) begin rem -= 500; push_ent(0, 3'b000, 0, 1, rem); end
    for (int i = 0; i < n100; i++) begin rem -= 100; push_ent(0, 3'b000, 1, 0, rem); end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tl.delete();
      m_credit = 0;
      e_cred = 0; e_beb = 3'b000; e_disp = 0; e_c100 = 0; e_c500 = 0;
      e_rech = 0; e_falta = 0; e_ocup = 0;
    end else begin
      automatic logic coin = suma100 | suma500;
      automatic int   val  = (suma100 ? 100 : 0) + (suma500 ? 500 : 0);
      automatic int   p    = price_of(sel);
      ent_t e;
      e_rech = 0;
      e_falta = 0;
      if (e_ocup) begin
        e_rech = coin;
      end else if (cancel) begin
        e_rech = coin;
        push_ent(0, 3'b000, 0, 0, m_credit);
        push_change(m_credit);
        m_credit = 0;
      end else if (p > 0) begin
        e_rech = coin;
        if (m_credit >= p) begin
          m_credit -= p;
          for (int i = 0; i < D; i++) push_ent(1, sel, 0, 0, m_credit);
          push_change(m_credit);
          m_credit = 0;
        end else begin
          e_falta = 1;
        end
      end else if (coin) begin
        if (m_credit + val > MAXC) e_rech = 1;
        else                       m_credit += val;
      end
      if (tl.size() > 0) begin
        e = tl.pop_front();
        e_disp = e.disp; e_beb = e.beb; e_c100 = e.c100; e_c500 = e.c500;
        e_cred = e.cred; e_ocup = 1;
      end else begin
        e_disp = 0; e_beb = 3'b000; e_c100 = 0; e_c500 = 0;
        e_cred = m_credit; e_ocup = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("credito",   32'(credito),   32'(e_cred));
      chk("dispensar", 32'(dispensar), 32'(e_disp));
      chk("bebida",    32'(bebida),    32'(e_beb));
      chk("cambio100", 32'(cambio100), 32'(e_c100));
      chk("cambio500", 32'(cambio500), 32'(e_c500));
      chk("rechazo",   32'(rechazo),   32'(e_rech));
      chk("falta",     32'(falta),     32'(e_falta));
      chk("ocupado",   32'(ocupado),   32'(e_ocup));
    end
  end

  task automatic step(input logic a, input logic b, input logic [2:0] s);
    @(negedge clk);
    suma100 = a; suma500 = b; sel = s; cancel = 1'b0;
    $display("t=%0t step suma100=%0b suma500=%0b sel=%b credito=%0d", $time, a, b, s, credito);
  endtask

  task automatic do_cancel();
    @(negedge clk);
    suma100 = 1'b0; suma500 = 1'b0; sel = 3'b000; cancel = 1'b1;
    $display("t=%0t step cancel credito=%0d", $time, credito);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_credito", 32'(credito), 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_bebida",  32'(bebida),  0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Purchase with change: 1000 credit, drink B, three 100 coins back.
    step(0, 1, 3'b000); step(0, 1, 3'b000); step(0, 0, 3'b000);
    chk("t1_credit_before", 32'(credito), 1000);
    step(0, 0, 3'b010); step(0, 0, 3'b000);
    chk("t1_disp_first", 32'(dispensar), 1);
    chk("t1_bebida",     32'(bebida), 3'b010);
    chk("t1_credit_after", 32'(credito), 300);
    repeat (3) step(0, 0, 3'b000);
    chk("t1_disp_last", 32'(dispensar), 1);
    step(0, 0, 3'b000);
    chk("t1_first_c100", 32'(cambio100), 1);
    chk("t1_credit_200", 32'(credito), 200);
    repeat (3) step(0, 0, 3'b000);
    chk("t1_ocupado_end", 32'(ocupado), 0);
    chk("t1_credit_end",  32'(credito), 0);

    // Insufficient credit, then invalid selections.
    step(0, 1, 3'b000); step(0, 0, 3'b100); step(0, 0, 3'b000);
    chk("t2_falta", 32'(falta), 1);
    chk("t2_credit", 32'(credito), 500);
    chk("t2_disp", 32'(dispensar), 0);
    step(0, 0, 3'b011); step(0, 0, 3'b000);
    chk("t2_invalid_sel", 32'(falta), 0);
    step(1, 0, 3'b110); step(0, 0, 3'b000);
    chk("t2_invalid_sel_coin", 32'(credito), 600);

    // Saturation at MAX_CREDIT.
    step(0, 1, 3'b000); step(0, 1, 3'b000);
    repeat (4) step(1, 0, 3'b000);
    step(1, 0, 3'b000); step(0, 0, 3'b000);
    chk("t3_rech_full", 32'(rechazo), 1);
    chk("t3_credit_full", 32'(credito), 2000);
    step(0, 0, 3'b100);
    repeat (8) step(0, 0, 3'b000);
    chk("t3_drained", 32'(credito), 0);
    repeat (3) step(0, 1, 3'b000);
    step(1, 1, 3'b000); step(0, 0, 3'b000);
    chk("t3_rech_600", 32'(rechazo), 1);
    chk("t3_credit_1500", 32'(credito), 1500);

    // Coins while busy, then sel and coin together.
    step(0, 0, 3'b010); step(0, 1, 3'b000); step(0, 0, 3'b000);
    chk("t4_rech_busy", 32'(rechazo), 1);
    chk("t4_credit_800", 32'(credito), 800);
    repeat (8) step(0, 0, 3'b000);
    chk("t4_idle", 32'(ocupado), 0);
    step(0, 1, 3'b000); step(1, 0, 3'b001); step(0, 0, 3'b000);
    chk("t4_rech_selcoin", 32'(rechazo), 1);
    chk("t4_served", 32'(dispensar), 1);
    chk("t4_credit_0", 32'(credito), 0);
    repeat (5) step(0, 0, 3'b000);

    // Reset during the first change cycle.
    step(0, 1, 3'b000); step(0, 1, 3'b000); step(0, 0, 3'b001);
    repeat (5) step(0, 0, 3'b000);
    chk("t5_first_c500", 32'(cambio500), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_credito",   32'(credito), 0);
    chk("t5_rst_cambio500", 32'(cambio500), 0);
    chk("t5_rst_ocupado",   32'(ocupado), 0);
    step(0, 0, 3'b000);
    rst = 1'b0;
    repeat (4) step(0, 0, 3'b000);
    chk("t5_after_rst", 32'(credito), 0);

`ifdef CANCEL_EN
    step(0, 1, 3'b000); step(1, 0, 3'b000); step(1, 0, 3'b000);
    do_cancel(); step(0, 0, 3'b000);
    chk("t6_busy", 32'(ocupado), 1);
    step(0, 0, 3'b000);
    chk("t6_c500", 32'(cambio500), 1);
    repeat (3) step(0, 0, 3'b000);
    chk("t6_idle", 32'(ocupado), 0);
    do_cancel(); step(0, 0, 3'b000);
    chk("t6_idle_cancel", 32'(ocupado), 1);
    step(0, 0, 3'b000);
`endif

    step(0, 0, 3'b000);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
